munoc_response_link_arbiter: RTL and testbench

- Shares one slave-side response network link among NUM_REQ response packetizers. Each packetizer emits B or R response flits in the BNI link format {valid, transaction_last, packet_last, flit}.
- Arbitration is round-robin at transaction granularity. A granted requester keeps the link until its transaction-last flit is accepted, so B and R packets from different requesters never interleave.
- A one-entry registered output stage drives the network link and absorbs link backpressure.

---
 rtl/munoc_response_link_arbiter.sv | 110 +++++++++++
 tb/tb_munoc_response_link_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/munoc_response_link_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | munoc_response_link_arbiter: transaction-granular round-robin sharing of   |
// | one response link among NUM_REQ packetizers.   Rev 1.0                    |
// +----------------------------------------------------------------------------+
module munoc_response_link_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int BW_FLIT = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ*(BW_FLIT+3)-1:0]   req_link_list,
  output logic [NUM_REQ-1:0]               req_ready_list,
  output logic [BW_FLIT+2:0]               res_link,
  input  logic                             res_ready,
  input  logic                             res_hold,
  output logic [NUM_REQ-1:0]               grant_onehot,
  output logic                             locked
);

  localparam int              c_LW     = BW_FLIT + 3;
  localparam int              c_PW     = $clog2(NUM_REQ);
  localparam logic [c_PW-1:0] c_LAST   = c_PW'(NUM_REQ - 1);
  localparam logic [c_PW:0]   c_NUM    = (c_PW + 1)'(NUM_REQ);
  localparam logic [0:0]      c_IDLE   = 1'b0;
  localparam logic [0:0]      c_LOCKED = 1'b1;

  logic [0:0]      r_state;
  logic [c_PW-1:0] r_ptr;
  logic [c_PW-1:0] r_owner;
  logic [c_LW-1:0] r_out;

  logic [c_LW-1:0]    w_slot [NUM_REQ];
  logic [NUM_REQ-1:0] w_valid;
  logic [c_PW-1:0]    w_grant_idx;
  logic               w_grant_any;
  logic [c_PW:0]      w_sum;
  logic [c_LW-1:0]    w_sel;
  logic               w_load_en;
  logic               w_accept;
  logic [c_PW-1:0]    w_next_ptr;

  generate
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
      assign w_slot[k]  = req_link_list[(k+1)*c_LW-1 -: c_LW];
      assign w_valid[k] = w_slot[k][c_LW-1];
    end
  endgenerate

  // Descending scan so the candidate closest to r_ptr is written last and wins.
  always_comb begin
    w_grant_idx = '0;
    w_grant_any = 1'b0;
    w_sum       = '0;
    if (r_state == c_LOCKED) begin
      w_grant_idx = r_owner;
      w_grant_any = 1'b1;
    end else begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        w_sum = {1'b0, r_ptr} + (c_PW + 1)'(i);
        if (w_sum >= c_NUM) w_sum = w_sum - c_NUM;
        if (w_valid[w_sum[c_PW-1:0]]) begin
          w_grant_idx = w_sum[c_PW-1:0];
          w_grant_any = 1'b1;
        end
      end
    end
  end

  assign w_sel      = w_slot[w_grant_idx];
  assign w_load_en  = ~r_out[c_LW-1] | res_ready;
  assign w_accept   = w_load_en & ~res_hold & ~rst & w_grant_any & w_sel[c_LW-1];
  assign w_next_ptr = (w_grant_idx == c_LAST) ? '0 : w_grant_idx + c_PW'(1);

  generate
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_grant
      assign grant_onehot[k]   = w_grant_any & (w_grant_idx == c_PW'(k));
      assign req_ready_list[k] = w_accept & grant_onehot[k];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_out   <= '0;
    end else begin
      if (w_accept) begin
        r_out <= {1'b1, w_sel[c_LW-2:0]};
      end else if (res_ready) begin
        r_out[c_LW-1] <= 1'b0;
      end
      if (w_accept) begin
        if (w_sel[c_LW-2]) begin
          r_state <= c_IDLE;
          r_ptr   <= w_next_ptr;
        end else begin
          r_state <= c_LOCKED;
          r_owner <= w_grant_idx;
        end
      end
    end
  end

  assign res_link = r_out;
  assign locked   = (r_state == c_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_munoc_response_link_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_munoc_response_link_arbiter: directed vectors for the response arbiter. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_munoc_response_link_arbiter;

  localparam int N  = 4;
  localparam int BW = 8;
  localparam int LW = BW + 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [LW-1:0]   slot [N];
  logic [N*LW-1:0] req_link_list;
  logic [N-1:0]    req_ready_list;
  logic [LW-1:0]   res_link;
  logic            res_ready;
  logic            res_hold;
  logic [N-1:0]    grant_onehot;
  logic            locked;

  int n_checks = 0;
  int n_fail   = 0;

  assign req_link_list = {slot[3], slot[2], slot[1], slot[0]};

  munoc_response_link_arbiter #(.NUM_REQ(N), .BW_FLIT(BW)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .req_link_list  (req_link_list),
    .req_ready_list (req_ready_list),
    .res_link       (res_link),
    .res_ready      (res_ready),
    .res_hold       (res_hold),
    .grant_onehot   (grant_onehot),
    .locked         (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] fl(input logic tl, input logic pl, input logic [7:0] f);
    return {1'b1, tl, pl, f};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all;
    for (int k = 0; k < N; k++) slot[k] = '0;
  endtask

  initial begin
    rst = 1'b1; res_ready = 1'b1; res_hold = 1'b0;
    clear_all();
    tick(); tick();
    slot[2] = fl(1'b1, 1'b0, 8'hEE);
    #1;
    chk("rst_link",   res_link, 0);
    chk("rst_locked", locked, 0);
    chk("rst_ready",  req_ready_list, 0);
    chk("rst_grant",  grant_onehot, 4'b0100);
    clear_all();
    rst = 1'b0;

    // Two single-flit B responses, slots 0 and 2
    slot[0] = fl(1'b1, 1'b0, 8'hA0);
    slot[2] = fl(1'b1, 1'b0, 8'hA2);
    #1;
    chk("b_grant0", grant_onehot, 4'b0001);
    chk("b_ready0", req_ready_list, 4'b0001);
    tick();
    chk("b_link0",   res_link, fl(1'b1, 1'b0, 8'hA0));
    chk("b_locked0", locked, 0);
    slot[0] = '0;
    #1;
    chk("b_grant2", grant_onehot, 4'b0100);
    chk("b_ready2", req_ready_list, 4'b0100);
    tick();
    chk("b_link2",   res_link, fl(1'b1, 1'b0, 8'hA2));
    chk("b_locked2", locked, 0);
    slot[2] = '0;

    // Hold with all slots valid; ptr is 3
    for (int k = 0; k < N; k++) slot[k] = fl(1'b1, 1'b0, 8'hC0 + 8'(k));
    res_hold = 1'b1;
    #1;
    chk("hold_grant", grant_onehot, 4'b1000);
    chk("hold_ready", req_ready_list, 0);
    tick();
    chk("hold_drain", res_link[LW-1], 0);
    tick();
    chk("hold_grant2", grant_onehot, 4'b1000);
    chk("hold_ready2", req_ready_list, 0);
    res_hold = 1'b0;
    #1;
    chk("unhold_ready", req_ready_list, 4'b1000);
    tick();
    chk("unhold_link", res_link, fl(1'b1, 1'b0, 8'hC3));
    clear_all();

    // 3-flit R on slot 1 while slot 3 waits; ptr is 0
    slot[1] = fl(1'b0, 1'b1, 8'h10);
    slot[3] = fl(1'b1, 1'b0, 8'h33);
    #1;
    chk("r_ready_h", req_ready_list, 4'b0010);
    tick();
    chk("r_locked_h", locked, 1);
    chk("r_link_h",   res_link, fl(1'b0, 1'b1, 8'h10));
    slot[1] = fl(1'b0, 1'b0, 8'h11);
    #1;
    chk("r_ready_d1", req_ready_list, 4'b0010);
    tick();
    chk("r_locked_d1", locked, 1);
    chk("r_link_d1",   res_link, fl(1'b0, 1'b0, 8'h11));
    slot[1] = fl(1'b1, 1'b0, 8'h12);
    #1;
    chk("r_ready_d2", req_ready_list, 4'b0010);
    tick();
    chk("r_locked_d2", locked, 0);
    chk("r_link_d2",   res_link, fl(1'b1, 1'b0, 8'h12));
    slot[1] = '0;
    #1;
    chk("r_ready_s3", req_ready_list, 4'b1000);
    tick();
    chk("r_link_s3", res_link, fl(1'b1, 1'b0, 8'h33));
    slot[3] = '0;

    // Owner slot 0 stalls mid-transaction; ptr is 0
    slot[0] = fl(1'b0, 1'b0, 8'h50);
    slot[1] = fl(1'b1, 1'b0, 8'h51);
    #1;
    chk("st_ready0", req_ready_list, 4'b0001);
    tick();
    chk("st_locked0", locked, 1);
    slot[0] = '0;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("st_ready_gap", req_ready_list, 0);
      chk("st_grant_gap", grant_onehot, 4'b0001);
      tick();
      chk("st_link_gap",   res_link[LW-1], 0);
      chk("st_locked_gap", locked, 1);
    end
    slot[0] = fl(1'b1, 1'b0, 8'h52);
    #1;
    chk("st_ready_res", req_ready_list, 4'b0001);
    tick();
    chk("st_link_res",   res_link, fl(1'b1, 1'b0, 8'h52));
    chk("st_locked_res", locked, 0);
    slot[0] = '0;
    #1;
    chk("st_ready_s1", req_ready_list, 4'b0010);
    tick();
    chk("st_link_s1", res_link, fl(1'b1, 1'b0, 8'h51));
    slot[1] = '0;

    // Link backpressure on a slot 2 stream; ptr is 2
    tick();
    chk("bp_drained", res_link[LW-1], 0);
    slot[2]   = fl(1'b0, 1'b0, 8'h60);
    res_ready = 1'b0;
    #1;
    chk("bp_ready_first", req_ready_list, 4'b0100);
    tick();
    chk("bp_link_first", res_link, fl(1'b0, 1'b0, 8'h60));
    slot[2] = fl(1'b0, 1'b0, 8'h61);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_ready_stall", req_ready_list, 0);
      tick();
      chk("bp_link_stall", res_link, fl(1'b0, 1'b0, 8'h60));
    end
    res_ready = 1'b1;
    #1;
    chk("bp_ready_go", req_ready_list, 4'b0100);
    tick();
    chk("bp_link_61", res_link, fl(1'b0, 1'b0, 8'h61));
    slot[2] = fl(1'b1, 1'b0, 8'h62);
    #1;
    chk("bp_ready_last", req_ready_list, 4'b0100);
    tick();
    chk("bp_link_62",   res_link, fl(1'b1, 1'b0, 8'h62));
    chk("bp_locked_end", locked, 0);
    slot[2] = '0;

    // Asynchronous reset while LOCKED with a full output register; ptr is 3
    slot[1] = fl(1'b0, 1'b0, 8'h70);
    #1;
    chk("ar_grant1", grant_onehot, 4'b0010);
    tick();
    chk("ar_locked", locked, 1);
    res_ready = 1'b0;
    slot[0]   = fl(1'b1, 1'b0, 8'h80);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_link",   res_link, 0);
    chk("ar_lock0",  locked, 0);
    chk("ar_ready",  req_ready_list, 0);
    chk("ar_grant0", grant_onehot, 4'b0001);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    res_ready = 1'b1;
    #1;
    chk("ar_ready_rel", req_ready_list, 4'b0001);
    tick();
    chk("ar_link_rel",   res_link, fl(1'b1, 1'b0, 8'h80));
    chk("ar_locked_rel", locked, 0);
    clear_all();

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
